ram_arb_2p: RTL and testbench
=============================

RAM_ARB_2P -- requirements
Module: ram_arb_2p

Interface
REQ-001 Parameter ADDR_W, default 4: RAM address width, 16 locations.
REQ-002 Parameter DATA_W, default 8: RAM data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_0, req_1  input  1 each  access request from port 0 or port 1.
REQ-006 we_0, we_1  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-007 addr_0, addr_1  input  ADDR_W each  access address.
REQ-008 wdata_0, wdata_1  input  DATA_W each  write data.
REQ-009 ack_0, ack_1  output  1 each  one-cycle grant pulse; the request has been issued to the RAM.
REQ-010 rvalid_0, rvalid_1  output  1 each  one-cycle pulse; rdata holds that port's read result.
REQ-011 rdata  output  DATA_W  read data shared by both ports, qualified by rvalid_x.
REQ-012 ram_wr  output  1  RAM write enable; 0 means the RAM reads.
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_din  output  DATA_W  RAM write data.
REQ-015 ram_dout  input  DATA_W  RAM registered read data, valid the cycle after a read is presented.

Function
REQ-016 Each port is eligible in a cycle when its req=1 and its ack is not high in that same cycle. Consequence: each port receives at most one grant every two cycles.
REQ-017 At each edge (rst=0), at most one eligible port is granted.
- If only one port is eligible, that port is granted.
- If both are eligible, the port holding priority is granted.
REQ-018 Priority is round-robin. After a grant to port x, priority passes to the other port. With no grant, priority is unchanged.
REQ-019 On a grant at edge E0, the following outputs are registered to be valid for the cycle after E0:
- ack_x=1
- ram_wr=we_x
- ram_addr=addr_x
- ram_din=wdata_x
REQ-020 With no grant, outputs behave as follows:
- ram_wr=0
- ram_addr and ram_din hold their previous values
- both acks=0
REQ-021 Read granted at E0: RAM samples at E1, and rvalid_x=1 in the cycle after E1 (latency 2 edges from grant).
REQ-022 rdata is ram_dout passed straight through, with no added register.
REQ-023 Write granted at E0 is committed by the RAM at E1. No rvalid is generated for a write.
REQ-024 Requester handshake rules:
- The requester holds req, we, addr and wdata stable until it sees ack high.
- It may drop req, or present the next request, in the ack cycle.
REQ-025 Back-to-back operation: alternating ports can sustain one access per cycle.
REQ-026 A write followed immediately by a read of the same address (either port) returns the new data, because the RAM commits in order.
REQ-027 rvalid_0 and rvalid_1 are never high in the same cycle. ack_0 and ack_1 are never high in the same cycle.

Reset
REQ-028 While rst=1 at an edge, the following are cleared: ack_0, ack_1, rvalid_0, rvalid_1, ram_wr, ram_addr, ram_din, the in-flight read tag. Priority is set to port 0.
REQ-029 Reset mid-operation:
- A read whose rvalid has not yet appeared is discarded, with no rvalid after reset.
- A write whose ack was already high completes in the RAM.
- RAM contents are not cleared.
- Requests pending during reset are re-arbitrated from the first edge with rst=0.

Structure
REQ-030 ADDR_W, DATA_W and a port-index typedef (PORT_0, PORT_1) are defined in shared package ram_arb_pkg.
REQ-031 Round-robin selection is a sub-module rr_arb2:
- Inputs: eligible[1:0], prio.
- Outputs: grant[1:0], next_prio.
- It is combinational; the priority register sits in ram_arb_2p.
REQ-032 A one-deep pipeline register (valid bit plus port tag) tracks the in-flight read between grant and rvalid.

Verification
REQ-033 Single read:
- Stimulus: reset, then port 0 writes 0xA5 to addr 3, then port 0 reads addr 3.
- Response: ack_0 one edge after each request; rvalid_0=1 with rdata=0xA5 two edges after the read grant.
REQ-034 Contention:
- Stimulus: req_0 and req_1 both held high with reads of addr 1 and addr 2 (contents 0x11 and 0x22).
- Response: grants alternate 0,1,0,1; rvalid_0 returns 0x11 and rvalid_1 returns 0x22 in alternating cycles; one access per cycle.
REQ-035 Single requester:
- Stimulus: only req_1 held high continuously for 6 edges.
- Response: ack_1 high every other cycle (3 grants); no duplicate grant for a held request.
REQ-036 Write-then-read:
- Stimulus: port 1 writes 0x3C to addr 15; port 0 reads addr 15 at the very next grant.
- Response: rvalid_0 with rdata=0x3C.
REQ-037 Reset mid-read:
- Stimulus: assert rst the cycle after a read ack.
- Response: no rvalid after reset; all outputs 0; first post-reset contention is granted to port 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared widths and port identifiers for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin selector; the priority state lives in the caller.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  port_t      prio,
  output logic [1:0] grant,
  output port_t      next_prio
);

  always_comb begin
    grant     = 2'b00;
    next_prio = prio;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio == PORT_0) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    // The winner yields priority to the other port; an idle cycle keeps it.
    if (grant[0]) begin
      next_prio = PORT_1;
    end else if (grant[1]) begin
      next_prio = PORT_0;
    end
  end

endmodule

// File: rtl/ram_arb_2p.sv
// Two requesters sharing one single-port RAM with a registered read port.
// Grants are round-robin; read data returns on a shared bus tagged by rvalid_x.
module ram_arb_2p #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              ack_0,
  output logic              ack_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  import ram_arb_pkg::*;

  logic [1:0]        eligible;
  logic [1:0]        grant;
  port_t             prio;
  port_t             next_prio;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              rd_vld_p0;
  port_t             rd_tag_p0;

  // A port whose ack is high this cycle is still holding the request just served.
  assign eligible = {req_1 & ~ack_1, req_0 & ~ack_0};

  rr_arb2 u_rr_arb2 (
    .eligible  (eligible),
    .prio      (prio),
    .grant     (grant),
    .next_prio (next_prio)
  );

  always_comb begin
    gnt_we    = we_0;
    gnt_addr  = addr_0;
    gnt_wdata = wdata_0;
    if (grant[1]) begin
      gnt_we    = we_1;
      gnt_addr  = addr_1;
      gnt_wdata = wdata_1;
    end
  end

  // Stage p0: grant issued to the RAM, read tag captured.
  // Stage p1: RAM has sampled the read; rvalid lines up with ram_dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_0     <= 1'b0;
      ack_1     <= 1'b0;
      rvalid_0  <= 1'b0;
      rvalid_1  <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rd_vld_p0 <= 1'b0;
      rd_tag_p0 <= PORT_0;
      prio      <= PORT_0;
    end else begin
      ack_0     <= grant[0];
      ack_1     <= grant[1];
      prio      <= next_prio;
      rvalid_0  <= rd_vld_p0 && (rd_tag_p0 == PORT_0);
      rvalid_1  <= rd_vld_p0 && (rd_tag_p0 == PORT_1);
      rd_vld_p0 <= (|grant) && !gnt_we;
      rd_tag_p0 <= grant[1] ? PORT_1 : PORT_0;
      if (|grant) begin
        ram_wr   <= gnt_we;
        ram_addr <= gnt_addr;
        ram_din  <= gnt_wdata;
      end else begin
        ram_wr   <= 1'b0;
      end
    end
  end

  assign rdata = ram_dout;

endmodule

// File: tb/tb_ram_arb_2p.sv
// Bench for ram_arb_2p: directed scenarios plus random traffic against a
// transaction-level model (grant order, memory image, queue of pending reads).
module tb_ram_arb_2p;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_0, req_1, we_0, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          ack_0, ack_1, rvalid_0, rvalid_1, ram_wr;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  logic          r_req [2];
  logic          r_we [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wdata [2];

  assign req_0   = r_req[0];
  assign req_1   = r_req[1];
  assign we_0    = r_we[0];
  assign we_1    = r_we[1];
  assign addr_0  = r_addr[0];
  assign addr_1  = r_addr[1];
  assign wdata_0 = r_wdata[0];
  assign wdata_1 = r_wdata[1];

  always #5 clk = ~clk;

  ram_arb_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_0    (req_0),
    .req_1    (req_1),
    .we_0     (we_0),
    .we_1     (we_1),
    .addr_0   (addr_0),
    .addr_1   (addr_1),
    .wdata_0  (wdata_0),
    .wdata_1  (wdata_1),
    .ack_0    (ack_0),
    .ack_1    (ack_1),
    .rvalid_0 (rvalid_0),
    .rvalid_1 (rvalid_1),
    .rdata    (rdata),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Synchronous RAM with registered read output; contents survive reset.
  logic [DW-1:0] tb_mem [16];
  always @(posedge clk) begin
    if (ram_wr) tb_mem[ram_addr] <= ram_din;
    else        ram_dout <= tb_mem[ram_addr];
  end

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t           pend [$];
  logic [DW-1:0] ref_mem [16];
  int            cyc = 0;
  int            m_prio = 0;
  bit            m_ack [2];
  bit            m_rv [2];
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_rdata;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, update the model from the inputs sampled at that edge,
  // then compare every DUT output with the model.
  task automatic step(input bit r);
    bit            s_req [2];
    bit            s_we [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_wd [2];
    bit            el [2];
    int            g;
    rd_t           e;
    rst = r;
    for (int p = 0; p < 2; p++) begin
      s_req[p]  = r_req[p];
      s_we[p]   = r_we[p];
      s_addr[p] = r_addr[p];
      s_wd[p]   = r_wdata[p];
    end
    @(posedge clk);
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (r) begin
      m_ack[0] = 1'b0;
      m_ack[1] = 1'b0;
      m_wr     = 1'b0;
      m_addr   = '0;
      m_din    = '0;
      m_prio   = 0;
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        m_rv[e.port] = 1'b1;
        m_rdata      = e.data;
      end
      for (int p = 0; p < 2; p++) el[p] = s_req[p] && !m_ack[p];
      g = -1;
      if (el[0] && el[1]) g = m_prio;
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
      m_ack[0] = (g == 0);
      m_ack[1] = (g == 1);
      if (g >= 0) begin
        m_wr   = s_we[g];
        m_addr = s_addr[g];
        m_din  = s_wd[g];
        m_prio = 1 - g;
        if (s_we[g]) ref_mem[s_addr[g]] = s_wd[g];
        else pend.push_back('{port: g, data: ref_mem[s_addr[g]], due: cyc + 1});
      end else begin
        m_wr = 1'b0;
      end
    end
    cyc++;
    #1;
    check("ack_0", 32'(ack_0), 32'(m_ack[0]));
    check("ack_1", 32'(ack_1), 32'(m_ack[1]));
    check("rvalid_0", 32'(rvalid_0), 32'(m_rv[0]));
    check("rvalid_1", 32'(rvalid_1), 32'(m_rv[1]));
    check("ram_wr", 32'(ram_wr), 32'(m_wr));
    check("ram_addr", 32'(ram_addr), 32'(m_addr));
    check("ram_din", 32'(ram_din), 32'(m_din));
    if (m_rv[0] || m_rv[1]) check("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  // Present one request and hold it until acknowledged, then drop it in the ack cycle.
  task automatic do_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    r_req[p]   = 1'b1;
    r_we[p]    = we;
    r_addr[p]  = a;
    r_wdata[p] = d;
    step(1'b0);
    n++;
    while (!m_ack[p] && n < 8) begin
      step(1'b0);
      n++;
    end
    check("req_acked", 32'((p == 1) ? ack_1 : ack_0), 32'd1);
    r_req[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  int cnt;

  initial begin
    for (int p = 0; p < 2; p++) begin
      r_req[p]   = 1'b0;
      r_we[p]    = 1'b0;
      r_addr[p]  = '0;
      r_wdata[p] = '0;
    end
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    check("rst_outputs", 32'({ack_0, ack_1, rvalid_0, rvalid_1, ram_wr, ram_addr, ram_din}), 32'd0);

    // Fill the RAM so every later read has a known value.
    for (int i = 0; i < 16; i++) do_req(i % 2, 1'b1, AW'(i), DW'($urandom));
    idle(2);

    // Single write then read on port 0.
    do_req(0, 1'b1, 4'd3, 8'hA5);
    do_req(0, 1'b0, 4'd3, 8'h00);
    step(1'b0);
    check("sr_rvalid_0", 32'(rvalid_0), 32'd1);
    check("sr_rdata", 32'(rdata), 32'hA5);
    idle(2);

    // Contention: both ports hold reads, grants alternate starting at port 0.
    do_req(0, 1'b1, 4'd1, 8'h11);
    do_req(1, 1'b1, 4'd2, 8'h22);
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 4'd1;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 4'd2;
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      check("ct_ack_0", 32'(ack_0), 32'(k % 2 == 0));
      check("ct_ack_1", 32'(ack_1), 32'(k % 2 == 1));
      if (k >= 1) begin
        check("ct_rvalid_0", 32'(rvalid_0), 32'(k % 2 == 1));
        check("ct_rdata", 32'(rdata), (k % 2 == 1) ? 32'h11 : 32'h22);
      end
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    idle(3);

    // Single requester held for six edges.
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 4'd5;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0);
      cnt += int'(ack_1);
    end
    check("sq_grants", 32'(cnt), 32'd3);
    r_req[1] = 1'b0;
    idle(3);

    // Write on port 1 immediately followed by a read of the same address on port 0.
    do_req(1, 1'b1, 4'd15, 8'h3C);
    do_req(0, 1'b0, 4'd15, 8'h00);
    step(1'b0);
    check("wr_rd_rvalid_0", 32'(rvalid_0), 32'd1);
    check("wr_rd_rdata", 32'(rdata), 32'h3C);
    idle(2);

    // Reset while a read is in flight.
    do_req(0, 1'b0, 4'd7, 8'h00);
    step(1'b1);
    check("rr_outputs", 32'({ack_0, ack_1, rvalid_0, rvalid_1, ram_wr, ram_addr, ram_din}), 32'd0);
    step(1'b1);
    step(1'b0);
    check("rr_no_rvalid", 32'({rvalid_0, rvalid_1}), 32'd0);
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 4'd1;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 4'd2;
    step(1'b0);
    check("rr_first_grant", 32'({ack_1, ack_0}), 32'b01);
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    idle(3);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!r_req[p] || m_ack[p]) begin
          r_req[p]   = ($urandom_range(0, 9) < 6);
          r_we[p]    = $urandom_range(0, 1) == 1;
          r_addr[p]  = AW'($urandom_range(0, 15));
          r_wdata[p] = DW'($urandom);
        end
      end
      step($urandom_range(0, 99) == 0);
      check("excl_ack", 32'(ack_0 & ack_1), 32'd0);
      check("excl_rvalid", 32'(rvalid_0 & rvalid_1), 32'd0);
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
